mpu_load_store_unit: RTL and testbench
======================================

// Module: mpu_load_store_unit
// PURPOSE
//  MPU-side responder for the matrix memory load/store bus. Serves load_en/store_en
//  requests from the testbench/host side and moves matrices between that bus and the
//  matrix register file. Loads: accepts a row-major element stream and issues
//  register-file writes. Stores: issues register-file reads and streams elements out.
// PARAMETERS
//  REG_RD_LAT  1  register-file read latency in cycles; only 1 is supported
//  Widths come from global_defs: M, N, FPBITS, MBITS, NBITS, MATRIX_REG_BITS (a field [X:0] is X+1 bits).
// PORTS
//  clk                input   1            clock, all flops on posedge
//  rst                input   1            asynchronous, active-low reset
//  load_en            input   1            load request, held until ack stream ends
//  store_en           input   1            store request, held until stream ends
//  mem_load_element   input   FPBITS+1     incoming element, row-major
//  mem_m_load_size    input   MBITS+1      rows of incoming matrix (1..M)
//  mem_n_load_size    input   NBITS+1      cols of incoming matrix (1..N)
//  mem_load_addr      input   MRB+1        destination register (MRB = MATRIX_REG_BITS)
//  mem_store_addr     input   MRB+1        source register
//  mem_load_ack       output  1            high while load elements are accepted
//  mem_load_error     output  1            1-cycle pulse, illegal load size
//  mem_store_en       output  1            high while mem_store_element is valid
//  mem_store_error    output  1            1-cycle pulse, source register empty (size 0)
//  mem_store_element  output  FPBITS+1     outgoing element, row-major
//  mem_m_store_size   output  MBITS+1      rows of outgoing matrix
//  mem_n_store_size   output  NBITS+1      cols of outgoing matrix
//  reg_load_en        output  1            register-file write strobe
//  reg_load_addr      output  MRB+1        write register
//  reg_load_element   output  FPBITS+1     write data
//  reg_m_load_size    output  MBITS+1      size written with the matrix
//  reg_n_load_size    output  NBITS+1
//  reg_i_load_loc     output  MBITS+1      write row
//  reg_j_load_loc     output  NBITS+1      write col
//  reg_store_en       output  1            register-file read strobe
//  reg_store_addr     output  MRB+1        read register
//  reg_i_store_loc    output  MBITS+1      read row
//  reg_j_store_loc    output  NBITS+1      read col
//  reg_store_element  input   FPBITS+1     read data, REG_RD_LAT after strobe
//  reg_m_store_size   input   MBITS+1      stored size of the register, valid with read data
//  reg_n_store_size   input   NBITS+1
// BEHAVIOUR
//  Reset (rst=0, async): every output 0; state IDLE; counters 0. Reset mid-transfer aborts it; no further reg writes.
//  FSM: IDLE, LD_XFER, LD_WAIT, ST_PROBE, ST_XFER, ST_WAIT.
//  IDLE: load_en sampled high -> latch sizes/addr. If m=0, n=0, m>M or n>N: mem_load_error=1 for 1 cycle, -> LD_WAIT.
//    Otherwise -> LD_XFER. load_en and store_en both high: load wins. store_en alone -> ST_PROBE.
//  LD_XFER: mem_load_ack=1 for exactly m*n cycles starting the cycle after acceptance. On each ack-high edge,
//    element k is sampled. The register write follows one cycle later (reg_load_en=1, i/j of k, latched addr/sizes).
//  i/j counter: j++ ; at j=n-1, j<=0 and i++; after k=m*n-1 -> LD_WAIT.
//  LD_WAIT: ack=0; wait load_en=0, then IDLE. Same for ST_WAIT with store_en.
//  ST_PROBE: read (0,0), one strobe. Returned sizes are latched. If either size is 0: mem_store_error pulse,
//    -> ST_WAIT. Else -> ST_XFER.
//  ST_XFER: pipelined reads, one per cycle, row-major. mem_store_en=1 with each returned element, for exactly
//    m*n consecutive cycles; mem_m/n_store_size are held for the whole stream. Last element -> ST_WAIT.
//  load_en/store_en dropping mid-transfer is ignored; the transfer completes.
//  Counters sized $clog2(M*N)+1 with no wrap past m*n.
// STRUCTURE
//  mpu_pkg: lsu_state_e enum and the size-legality function.
//  Sub-module mpu_lsu_idx_counter: row-major i/j/k counter with start, step, and last outputs.
//    Instantiated twice: load write index and store read index.
// TESTING
//  Load 2x3 into reg 1, elements 1.0..6.0 -> ack high 6 cycles; writes (0,0)..(1,2) in order, sizes 2/3.
//  Store reg 1 after the above -> mem_store_en high 6 consecutive cycles; 1.0..6.0; sizes 2/3.
//  Load with m=0 (and separately n=N+1) -> one mem_load_error pulse; no ack; no reg_load_en.
//  Store from a never-written register -> one mem_store_error pulse; mem_store_en never rises.
//  load_en and store_en rise together -> load runs first; the store runs after load_en drops.
//  rst low after the 3rd ack of an MxN load -> all outputs 0 next edge; a fresh 1x1 load then completes normally.

Source files
------------

// File: rtl/mpu_pkg.sv
// Shared widths, FSM state type and size-legality check for the MPU load/store unit.
package mpu_pkg;
    localparam int M               = 4;
    localparam int N               = 4;
    localparam int FPBITS          = 31;
    localparam int MBITS           = 2;
    localparam int NBITS           = 2;
    localparam int MATRIX_REG_BITS = 2;
    localparam int IDX_BITS        = $clog2(M * N) + 1;

    typedef enum logic [2:0] {
        IDLE,
        LD_XFER,
        LD_WAIT,
        ST_PROBE,
        ST_XFER,
        ST_WAIT
    } lsu_state_e;

    function automatic logic size_legal(input logic [MBITS:0] m, input logic [NBITS:0] n);
        return (m != '0) && (n != '0) && (m <= (MBITS+1)'(M)) && (n <= (NBITS+1)'(N));
    endfunction
endpackage

// File: rtl/mpu_lsu_idx_counter.sv
// Row-major (i,j) walker over an m x n matrix; holds at the last element instead of wrapping.
module mpu_lsu_idx_counter
    import mpu_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           step,
    input  logic [MBITS:0] m,
    input  logic [NBITS:0] n,
    output logic [MBITS:0] i,
    output logic [NBITS:0] j,
    output logic           last
);
    logic [IDX_BITS-1:0] k;
    logic [IDX_BITS-1:0] total;

    assign total = IDX_BITS'(m) * IDX_BITS'(n);
    assign last  = (k == total - IDX_BITS'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i <= '0;
            j <= '0;
            k <= '0;
        end else if (start) begin
            i <= '0;
            j <= '0;
            k <= '0;
        end else if (step && !last) begin
            k <= k + IDX_BITS'(1);
            if (j == n - (NBITS+1)'(1)) begin
                j <= '0;
                i <= i + (MBITS+1)'(1);
            end else begin
                j <= j + (NBITS+1)'(1);
            end
        end
    end
endmodule

// File: rtl/mpu_load_store_unit.sv
// MPU-side responder moving matrices between the memory load/store bus and the matrix register file.
module mpu_load_store_unit
    import mpu_pkg::*;
#(
    parameter int REG_RD_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_en,
    input  logic                     store_en,
    input  logic [FPBITS:0]          mem_load_element,
    input  logic [MBITS:0]           mem_m_load_size,
    input  logic [NBITS:0]           mem_n_load_size,
    input  logic [MATRIX_REG_BITS:0] mem_load_addr,
    input  logic [MATRIX_REG_BITS:0] mem_store_addr,
    output logic                     mem_load_ack,
    output logic                     mem_load_error,
    output logic                     mem_store_en,
    output logic                     mem_store_error,
    output logic [FPBITS:0]          mem_store_element,
    output logic [MBITS:0]           mem_m_store_size,
    output logic [NBITS:0]           mem_n_store_size,
    output logic                     reg_load_en,
    output logic [MATRIX_REG_BITS:0] reg_load_addr,
    output logic [FPBITS:0]          reg_load_element,
    output logic [MBITS:0]           reg_m_load_size,
    output logic [NBITS:0]           reg_n_load_size,
    output logic [MBITS:0]           reg_i_load_loc,
    output logic [NBITS:0]           reg_j_load_loc,
    output logic                     reg_store_en,
    output logic [MATRIX_REG_BITS:0] reg_store_addr,
    output logic [MBITS:0]           reg_i_store_loc,
    output logic [NBITS:0]           reg_j_store_loc,
    input  logic [FPBITS:0]          reg_store_element,
    input  logic [MBITS:0]           reg_m_store_size,
    input  logic [NBITS:0]           reg_n_store_size
);
    if (REG_RD_LAT != 1) begin : g_rd_lat_check
        $error("mpu_load_store_unit supports REG_RD_LAT == 1 only");
    end

    lsu_state_e state, state_nxt;

    logic           probe_sent, rd_pending, rd_done;
    logic [MBITS:0] ld_i, st_i;
    logic [NBITS:0] ld_j, st_j;
    logic           ld_last, st_last;
    logic           ld_req, ld_ok, st_req, ld_step, st_step, probe_ready, st_ok;

    assign ld_req      = (state == IDLE) && load_en;
    assign ld_ok       = size_legal(mem_m_load_size, mem_n_load_size);
    assign st_req      = (state == IDLE) && !load_en && store_en;
    assign ld_step     = (state == LD_XFER);
    assign st_step     = (state == ST_XFER) && !rd_done;
    assign probe_ready = (state == ST_PROBE) && probe_sent;
    assign st_ok       = (reg_m_store_size != '0) && (reg_n_store_size != '0);

    assign mem_load_ack    = ld_step;
    assign reg_store_en    = ((state == ST_PROBE) && !probe_sent) || st_step;
    assign reg_i_store_loc = st_i;
    assign reg_j_store_loc = st_j;

    mpu_lsu_idx_counter u_ld_idx (
        .clk   (clk),
        .rst   (rst),
        .start (ld_req),
        .step  (ld_step),
        .m     (reg_m_load_size),
        .n     (reg_n_load_size),
        .i     (ld_i),
        .j     (ld_j),
        .last  (ld_last)
    );

    mpu_lsu_idx_counter u_st_idx (
        .clk   (clk),
        .rst   (rst),
        .start (st_req),
        .step  (st_step),
        .m     (mem_m_store_size),
        .n     (mem_n_store_size),
        .i     (st_i),
        .j     (st_j),
        .last  (st_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // A store ends once the read issued for its last element has come back.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (load_en)       state_nxt = ld_ok ? LD_XFER : LD_WAIT;
                else if (store_en) state_nxt = ST_PROBE;
            end
            LD_XFER:  if (ld_last) state_nxt = LD_WAIT;
            LD_WAIT:  if (!load_en) state_nxt = IDLE;
            ST_PROBE: if (probe_sent) state_nxt = st_ok ? ST_XFER : ST_WAIT;
            ST_XFER:  if (rd_pending && rd_done) state_nxt = ST_WAIT;
            ST_WAIT:  if (!store_en) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_load_error    <= 1'b0;
            mem_store_error   <= 1'b0;
            mem_store_en      <= 1'b0;
            mem_store_element <= '0;
            mem_m_store_size  <= '0;
            mem_n_store_size  <= '0;
            reg_load_en       <= 1'b0;
            reg_load_addr     <= '0;
            reg_load_element  <= '0;
            reg_m_load_size   <= '0;
            reg_n_load_size   <= '0;
            reg_i_load_loc    <= '0;
            reg_j_load_loc    <= '0;
            reg_store_addr    <= '0;
            probe_sent        <= 1'b0;
            rd_pending        <= 1'b0;
            rd_done           <= 1'b0;
        end else begin
            mem_load_error  <= ld_req && !ld_ok;
            mem_store_error <= probe_ready && !st_ok;
            probe_sent      <= (state == ST_PROBE) && !probe_sent;
            rd_pending      <= st_step;
            reg_load_en     <= ld_step;
            mem_store_en    <= (state == ST_XFER) && rd_pending;
            if (ld_req) begin
                reg_load_addr   <= mem_load_addr;
                reg_m_load_size <= mem_m_load_size;
                reg_n_load_size <= mem_n_load_size;
            end
            if (ld_step) begin
                reg_load_element <= mem_load_element;
                reg_i_load_loc   <= ld_i;
                reg_j_load_loc   <= ld_j;
            end
            if (st_req) begin
                reg_store_addr <= mem_store_addr;
                rd_done        <= 1'b0;
            end else if (st_step && st_last) begin
                rd_done <= 1'b1;
            end
            if (probe_ready && st_ok) begin
                mem_m_store_size <= reg_m_store_size;
                mem_n_store_size <= reg_n_store_size;
            end
            if ((state == ST_XFER) && rd_pending) mem_store_element <= reg_store_element;
        end
    end
endmodule

// File: tb/tb_mpu_load_store_unit.sv
// Randomized bench for mpu_load_store_unit with a register-file model and a flat row-major reference.
module tb_mpu_load_store_unit;
    logic        clk, rst, load_en, store_en;
    logic [31:0] mem_load_element;
    logic [2:0]  mem_m_load_size, mem_n_load_size, mem_load_addr, mem_store_addr;
    logic        mem_load_ack, mem_load_error, mem_store_en, mem_store_error;
    logic [31:0] mem_store_element;
    logic [2:0]  mem_m_store_size, mem_n_store_size;
    logic        reg_load_en;
    logic [2:0]  reg_load_addr, reg_m_load_size, reg_n_load_size, reg_i_load_loc, reg_j_load_loc;
    logic [31:0] reg_load_element;
    logic        reg_store_en;
    logic [2:0]  reg_store_addr, reg_i_store_loc, reg_j_store_loc;
    bit   [31:0] rd_e;
    bit   [2:0]  rd_m, rd_n;
    logic [99:0] all_outs;

    typedef struct { logic [2:0] addr, i, j, m, n; logic [31:0] e; int cyc; } wr_t;
    typedef struct { logic [31:0] e; logic [2:0] m, n; int cyc; } st_t;

    int  total = 0, bad = 0;
    int  cyc_cnt = 0, ack_cycles = 0, ld_err_cnt = 0, st_err_cnt = 0, st_runs = 0;
    bit  prev_st = 0;
    wr_t wr_q[$];
    st_t st_q[$];

    bit   [31:0] rf_e [8][4][4];
    bit   [2:0]  rf_m [8];
    bit   [2:0]  rf_n [8];
    logic [31:0] ld_data [16];
    logic [31:0] ref_mat [8][16];
    int          ref_m [8];
    int          ref_n [8];

    mpu_load_store_unit dut (
        .clk(clk), .rst(rst), .load_en(load_en), .store_en(store_en),
        .mem_load_element(mem_load_element), .mem_m_load_size(mem_m_load_size),
        .mem_n_load_size(mem_n_load_size), .mem_load_addr(mem_load_addr),
        .mem_store_addr(mem_store_addr), .mem_load_ack(mem_load_ack),
        .mem_load_error(mem_load_error), .mem_store_en(mem_store_en),
        .mem_store_error(mem_store_error), .mem_store_element(mem_store_element),
        .mem_m_store_size(mem_m_store_size), .mem_n_store_size(mem_n_store_size),
        .reg_load_en(reg_load_en), .reg_load_addr(reg_load_addr),
        .reg_load_element(reg_load_element), .reg_m_load_size(reg_m_load_size),
        .reg_n_load_size(reg_n_load_size), .reg_i_load_loc(reg_i_load_loc),
        .reg_j_load_loc(reg_j_load_loc), .reg_store_en(reg_store_en),
        .reg_store_addr(reg_store_addr), .reg_i_store_loc(reg_i_store_loc),
        .reg_j_store_loc(reg_j_store_loc), .reg_store_element(rd_e),
        .reg_m_store_size(rd_m), .reg_n_store_size(rd_n)
    );

    assign all_outs = {mem_load_ack, mem_load_error, mem_store_en, mem_store_error,
                       mem_store_element, mem_m_store_size, mem_n_store_size,
                       reg_load_en, reg_load_addr, reg_load_element, reg_m_load_size,
                       reg_n_load_size, reg_i_load_loc, reg_j_load_loc, reg_store_en,
                       reg_store_addr, reg_i_store_loc, reg_j_store_loc};

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Register file: writes land on the strobe edge, reads return one cycle after the strobe.
    always @(posedge clk) begin
        if (reg_load_en) begin
            rf_e[reg_load_addr][reg_i_load_loc[1:0]][reg_j_load_loc[1:0]] <= reg_load_element;
            rf_m[reg_load_addr] <= reg_m_load_size;
            rf_n[reg_load_addr] <= reg_n_load_size;
        end
        if (reg_store_en) begin
            rd_e <= rf_e[reg_store_addr][reg_i_store_loc[1:0]][reg_j_store_loc[1:0]];
            rd_m <= rf_m[reg_store_addr];
            rd_n <= rf_n[reg_store_addr];
        end
    end

    always @(negedge clk) begin
        wr_t w;
        st_t s;
        cyc_cnt++;
        if (mem_load_ack) ack_cycles++;
        if (mem_load_error) ld_err_cnt++;
        if (mem_store_error) st_err_cnt++;
        if (reg_load_en) begin
            w.addr = reg_load_addr; w.i = reg_i_load_loc; w.j = reg_j_load_loc;
            w.m = reg_m_load_size; w.n = reg_n_load_size; w.e = reg_load_element; w.cyc = cyc_cnt;
            wr_q.push_back(w);
        end
        if (mem_store_en) begin
            s.e = mem_store_element; s.m = mem_m_store_size; s.n = mem_n_store_size; s.cyc = cyc_cnt;
            st_q.push_back(s);
            if (!prev_st) st_runs++;
        end
        prev_st = mem_store_en;
    end

    task automatic do_load(input int a, input int m, input int n, input bit with_store, input int sa);
        int  w0, a0, e0, k, exp_w;
        bit  legal, done;
        legal = (m >= 1) && (m <= 4) && (n >= 1) && (n <= 4);
        exp_w = legal ? m * n : 0;
        w0 = wr_q.size(); a0 = ack_cycles; e0 = ld_err_cnt; k = 0; done = 0;
        @(negedge clk);
        load_en = 1; mem_load_addr = 3'(a); mem_m_load_size = 3'(m); mem_n_load_size = 3'(n);
        if (with_store) begin
            store_en = 1; mem_store_addr = 3'(sa);
        end
        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            @(negedge clk); #1;
            if (mem_load_ack) begin
                mem_load_element = (k < 16) ? ld_data[k] : '0;
                k++;
            end else if (legal ? (k >= m * n) : (cyc >= 3)) begin
                done = 1;
            end
        end
        if (!done) begin
            total++; bad++;
            $display("[TB] FAIL load_timeout: acks seen=%0d, required=%0d", k, exp_w);
        end
        load_en = 0; mem_load_element = '0;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (ack_cycles - a0 !== exp_w) begin
            bad++; $display("[TB] FAIL load_ack_cycles: got %0d, want %0d", ack_cycles - a0, exp_w);
        end
        total++;
        if (ld_err_cnt - e0 !== (legal ? 0 : 1)) begin
            bad++; $display("[TB] FAIL load_error_cycles: got %0d, want %0d", ld_err_cnt - e0, legal ? 0 : 1);
        end
        total++;
        if (wr_q.size() - w0 !== exp_w) begin
            bad++; $display("[TB] FAIL load_write_count: got %0d, want %0d", wr_q.size() - w0, exp_w);
        end
        for (int x = 0; x < exp_w && (w0 + x) < wr_q.size(); x++) begin
            wr_t w;
            w = wr_q[w0 + x];
            total++;
            if (w.addr !== 3'(a) || w.i !== 3'(x / n) || w.j !== 3'(x % n) ||
                w.m !== 3'(m) || w.n !== 3'(n) || w.e !== ld_data[x]) begin
                bad++;
                $display("[TB] FAIL load_write[%0d]: got a=%0d i=%0d j=%0d m=%0d n=%0d e=%h, want a=%0d i=%0d j=%0d m=%0d n=%0d e=%h",
                         x, w.addr, w.i, w.j, w.m, w.n, w.e, a, x / n, x % n, m, n, ld_data[x]);
            end
        end
        if (legal) begin
            for (int x = 0; x < m * n; x++) ref_mat[a][x] = ld_data[x];
            ref_m[a] = m; ref_n[a] = n;
        end
    endtask

    task automatic do_store(input int a, input bit started, input int s0, input int r0, input int e0);
        bit expect_err, done;
        int len;
        expect_err = (ref_m[a] == 0);
        len = expect_err ? 0 : ref_m[a] * ref_n[a];
        done = 0;
        if (!started) begin
            @(negedge clk);
            store_en = 1; mem_store_addr = 3'(a);
        end
        for (int cyc = 0; cyc < 80 && !done; cyc++) begin
            @(negedge clk); #1;
            if (expect_err ? (cyc >= 8) : ((st_q.size() - s0 >= len) && !mem_store_en)) done = 1;
        end
        if (!done) begin
            total++; bad++;
            $display("[TB] FAIL store_timeout: elements seen=%0d, required=%0d", st_q.size() - s0, len);
        end
        store_en = 0;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (st_runs - r0 !== (expect_err ? 0 : 1)) begin
            bad++; $display("[TB] FAIL store_runs: got %0d, want %0d", st_runs - r0, expect_err ? 0 : 1);
        end
        total++;
        if (st_err_cnt - e0 !== (expect_err ? 1 : 0)) begin
            bad++; $display("[TB] FAIL store_error_cycles: got %0d, want %0d", st_err_cnt - e0, expect_err ? 1 : 0);
        end
        total++;
        if (st_q.size() - s0 !== len) begin
            bad++; $display("[TB] FAIL store_length: got %0d, want %0d", st_q.size() - s0, len);
        end
        for (int x = 0; x < len && (s0 + x) < st_q.size(); x++) begin
            st_t s;
            s = st_q[s0 + x];
            total++;
            if (s.e !== ref_mat[a][x] || s.m !== 3'(ref_m[a]) || s.n !== 3'(ref_n[a])) begin
                bad++;
                $display("[TB] FAIL store_elem[%0d]: got e=%h m=%0d n=%0d, want e=%h m=%0d n=%0d",
                         x, s.e, s.m, s.n, ref_mat[a][x], ref_m[a], ref_n[a]);
            end
        end
    endtask

    task automatic test_reset;
        rst = 0;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (all_outs !== '0) begin
            bad++; $display("[TB] FAIL reset_outputs: got %h, want 0", all_outs);
        end
        rst = 1;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (all_outs !== '0) begin
            bad++; $display("[TB] FAIL idle_outputs: got %h, want 0", all_outs);
        end
    endtask

    task automatic test_load_2x3;
        ld_data[0] = 32'h3f800000; ld_data[1] = 32'h40000000; ld_data[2] = 32'h40400000;
        ld_data[3] = 32'h40800000; ld_data[4] = 32'h40a00000; ld_data[5] = 32'h40c00000;
        do_load(1, 2, 3, 0, 0);
    endtask

    task automatic test_store_2x3;
        do_store(1, 0, st_q.size(), st_runs, st_err_cnt);
    endtask

    task automatic test_load_errors;
        do_load(2, 0, 2, 0, 0);
        do_load(2, 1, 5, 0, 0);
    endtask

    task automatic test_store_error;
        do_store(7, 0, st_q.size(), st_runs, st_err_cnt);
    endtask

    task automatic test_simultaneous;
        int s0, r0, e0;
        s0 = st_q.size(); r0 = st_runs; e0 = st_err_cnt;
        ld_data[0] = $urandom; ld_data[1] = $urandom;
        do_load(3, 1, 2, 1, 1);
        do_store(1, 1, s0, r0, e0);
        if (st_q.size() > s0 && wr_q.size() > 0) begin
            total++;
            if (st_q[s0].cyc <= wr_q[$].cyc) begin
                bad++;
                $display("[TB] FAIL load_before_store: first store cycle %0d, last write cycle %0d, want store later",
                         st_q[s0].cyc, wr_q[$].cyc);
            end
        end
    endtask

    task automatic test_reset_midload;
        int w0, wr_at_reset, k;
        w0 = wr_q.size(); k = 0;
        for (int x = 0; x < 16; x++) ld_data[x] = $urandom;
        @(negedge clk);
        load_en = 1; mem_load_addr = 3'd5; mem_m_load_size = 3'd4; mem_n_load_size = 3'd4;
        for (int cyc = 0; cyc < 20 && k < 3; cyc++) begin
            @(negedge clk); #1;
            if (mem_load_ack) begin
                mem_load_element = ld_data[k];
                k++;
            end
        end
        total++;
        if (k !== 3) begin
            bad++; $display("[TB] FAIL midload_ack_timeout: got %0d acks, want 3", k);
        end
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk); #1;
        total++;
        if (all_outs !== '0) begin
            bad++; $display("[TB] FAIL midload_reset_outputs: got %h, want 0", all_outs);
        end
        wr_at_reset = wr_q.size();
        load_en = 0; mem_load_element = '0;
        @(negedge clk); rst = 1;
        repeat (4) @(negedge clk);
        #1;
        total++;
        if (wr_q.size() !== wr_at_reset) begin
            bad++; $display("[TB] FAIL midload_writes_after_reset: got %0d, want 0", wr_q.size() - wr_at_reset);
        end
        total++;
        if (wr_at_reset - w0 !== 2) begin
            bad++; $display("[TB] FAIL midload_writes_before_reset: got %0d, want 2", wr_at_reset - w0);
        end
        ld_data[0] = $urandom;
        do_load(6, 1, 1, 0, 0);
        do_store(6, 0, st_q.size(), st_runs, st_err_cnt);
    endtask

    task automatic test_random;
        int a;
        for (int it = 0; it < 6; it++) begin
            for (int x = 0; x < 16; x++) ld_data[x] = $urandom;
            do_load($urandom_range(0, 4), $urandom_range(0, 5), $urandom_range(0, 5), 0, 0);
        end
        for (int it = 0; it < 6; it++) begin
            a = $urandom_range(0, 5);
            if (a == 5) a = 6;
            do_store(a, 0, st_q.size(), st_runs, st_err_cnt);
        end
    endtask

    initial begin
        rst = 0; load_en = 0; store_en = 0; mem_load_element = '0;
        mem_m_load_size = '0; mem_n_load_size = '0; mem_load_addr = '0; mem_store_addr = '0;
        for (int x = 0; x < 8; x++) begin
            ref_m[x] = 0; ref_n[x] = 0;
        end
        test_reset();
        test_load_2x3();
        test_store_2x3();
        test_load_errors();
        test_store_error();
        test_simultaneous();
        test_reset_midload();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
